// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_cmd bus: command encoding, MMIO addresses and
// responder state encoding. Imported by the responder and the control FSM.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_READ    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } resp_state_t;

    localparam logic [8:0] MMIO_LED_ADDR = 9'h100;
    localparam logic [8:0] MMIO_SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_responder_if.sv
// mem_cmd bus between the control FSM (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready, mem_err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready, mem_err
    );
endinterface

// File: rtl/mem_responder_ram_sp.sv
// ram_sp: single-port synchronous RAM, read-first, one-cycle read latency.
module ram_sp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: target end of the mem_cmd bus; services on-chip RAM and, when
// MEM_RESPONDER_MMIO_EN is defined, the LED (write) and switch (read) registers.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);
    localparam int               RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    resp_state_t       state_r;
    mem_cmd_t          cmd_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        wait_cnt_r;
    logic [DATA_W-1:0] read_data_r;
    logic              mem_ready_r;
    logic              mem_err_r;

    logic              ram_hit_s;
    logic              sw_hit_s;
    logic              led_hit_s;
    logic              rd_ram_s;
    logic              rd_sw_s;
    logic              resp_err_s;
    logic              ram_we_s;
    logic [RAM_AW-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_dout_s;
    logic [DATA_W-1:0] sw_word_s;

    assign ram_hit_s = ({1'b0, addr_r} < DEPTH_L);
    assign sw_word_s = {{(DATA_W-8){1'b0}}, sw_in};

`ifdef MEM_RESPONDER_MMIO_EN
    logic [7:0] led_r;
    logic       wr_led_s;
    assign sw_hit_s  = (addr_r == ADDR_W'(MMIO_SW_ADDR));
    assign led_hit_s = (addr_r == ADDR_W'(MMIO_LED_ADDR));
    assign wr_led_s  = (cmd_r == MEM_WRITE) && led_hit_s;
    assign led_out   = led_r;
`else
    assign sw_hit_s  = 1'b0;
    assign led_hit_s = 1'b0;
    assign led_out   = 8'h00;
`endif

    // Classify the latched command against the address map.
    always_comb begin
        rd_ram_s   = 1'b0;
        rd_sw_s    = 1'b0;
        resp_err_s = 1'b1;
        case (cmd_r)
            MEM_READ: begin
                rd_ram_s   = ram_hit_s;
                rd_sw_s    = sw_hit_s && !ram_hit_s;
                resp_err_s = !(ram_hit_s || sw_hit_s);
            end
            MEM_WRITE: begin
                resp_err_s = !(ram_hit_s || led_hit_s);
            end
            default: begin
                resp_err_s = 1'b1;
            end
        endcase
    end

    // The read is launched from the live bus address in IDLE so dout lands in RESP.
    assign ram_addr_s = (state_r == ST_IDLE) ? bus.mem_addr[RAM_AW-1:0] : addr_r[RAM_AW-1:0];
    assign ram_we_s   = (state_r == ST_RESP) && (cmd_r == MEM_WRITE) && ram_hit_s && !reset;

    ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (wdata_r),
        .dout (ram_dout_s)
    );

    // Transaction FSM: latch, optional stall, one-cycle response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_r       <= MEM_NONE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            wait_cnt_r  <= 4'd0;
            read_data_r <= {DATA_W{1'b0}};
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
            led_r       <= 8'h00;
`endif
        end else begin
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.mem_cmd != MEM_NONE) begin
                        cmd_r      <= mem_cmd_t'(bus.mem_cmd);
                        addr_r     <= bus.mem_addr;
                        wdata_r    <= bus.write_data;
                        wait_cnt_r <= WAIT_LOAD;
                        state_r    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    mem_ready_r <= 1'b1;
                    mem_err_r   <= resp_err_s;
                    if (rd_ram_s) begin
                        read_data_r <= ram_dout_s;
                    end else if (rd_sw_s) begin
                        read_data_r <= sw_word_s;
                    end
`ifdef MEM_RESPONDER_MMIO_EN
                    if (wr_led_s) begin
                        led_r <= wdata_r[7:0];
                    end
`endif
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_data = read_data_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_err   = mem_err_r;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (no stall / 3-cycle stall)
// driven with random and directed traffic against a transaction-level model.
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int TMO   = 40;
`ifdef MEM_RESPONDER_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [15:0] rd;
        logic [7:0]  led;
        int          sample_cyc;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0, rst3;
    logic [7:0] sw0, sw3, led0, led3;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.ADDR_W(9), .DATA_W(16)) if0 ();
    mem_responder_if #(.ADDR_W(9), .DATA_W(16)) if3 ();

    mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0), .sw_in(sw0), .led_out(led0));
    mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(if3), .sw_in(sw3), .led_out(led3));

    int          errors = 0;
    int          checks = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mdl_mem [2][DEPTH];
    logic [15:0] mdl_rd  [2];
    logic [7:0]  mdl_led [2];
    int          wait_of [2] = '{0, 3};
    int          rst_req [2] = '{0, 0};
    int          rst_done[2] = '{0, 0};
    bit          final_req  = 1'b0;
    bit          final_done = 1'b0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Reference model: applies one command's architectural effect and returns the response.
    function automatic exp_t predict(input int d, input logic [1:0] c, input logic [8:0] a,
                                     input logic [15:0] wd, input logic [7:0] sw, input int sample);
        exp_t e;
        bit   in_ram;
        in_ram = (int'(a) < DEPTH);
        e.err  = 1'b1;
        if (c == 2'b10) begin
            if (in_ram) begin
                mdl_rd[d] = mdl_mem[d][a[7:0]];
                e.err = 1'b0;
            end else if (MMIO && a == 9'h140) begin
                mdl_rd[d] = {8'h00, sw};
                e.err = 1'b0;
            end
        end else if (c == 2'b01) begin
            if (in_ram) begin
                mdl_mem[d][a[7:0]] = wd;
                e.err = 1'b0;
            end else if (MMIO && a == 9'h100) begin
                mdl_led[d] = wd[7:0];
                e.err = 1'b0;
            end
        end
        e.rd         = mdl_rd[d];
        e.led        = mdl_led[d];
        e.sample_cyc = sample;
        e.lat        = 1 + wait_of[d];
        return e;
    endfunction

    task automatic drive(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd);
        if (d == 0) begin
            if0.mem_cmd = c; if0.mem_addr = a; if0.write_data = wd;
        end else begin
            if3.mem_cmd = c; if3.mem_addr = a; if3.write_data = wd;
        end
    endtask

    function automatic logic ready_of(input int d);
        return (d == 0) ? if0.mem_ready : if3.mem_ready;
    endfunction

    // Issue one command at a negedge, then scramble the idle bus until the response.
    task automatic issue(input int d, input logic [1:0] c, input logic [8:0] a,
                         input logic [15:0] wd, input logic [7:0] sw);
        exp_t e;
        if (d == 0) sw0 = sw; else sw3 = sw;
        e = predict(d, c, a, wd, sw, cyc + 1);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        drive(d, c, a, wd);
        @(negedge clk);
        drive(d, 2'b00, 9'($urandom), 16'($urandom));
        for (int i = 0; i < TMO; i++) begin
            if (ready_of(d)) break;
            @(negedge clk);
            drive(d, 2'b00, 9'($urandom), 16'($urandom));
        end
    endtask

    task automatic check_resp(input int d, input exp_t e, input logic err,
                              input logic [15:0] rd, input logic [7:0] led);
        chk("mem_err", d, 32'(err), 32'(e.err));
        chk("read_data", d, 32'(rd), 32'(e.rd));
        chk("led_out", d, 32'(led), 32'(e.led));
        chk("latency", d, cyc - e.sample_cyc, e.lat);
    endtask

    // Monitor: pops expectations on every ready pulse, plus reset and drain checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if0.mem_ready) begin
                if (q0.size() == 0) chk("unexpected_ready", 0, 32'd1, 32'd0);
                else begin e = q0.pop_front(); check_resp(0, e, if0.mem_err, if0.read_data, led0); end
            end
            if (if3.mem_ready) begin
                if (q1.size() == 0) chk("unexpected_ready", 1, 32'd1, 32'd0);
                else begin e = q1.pop_front(); check_resp(1, e, if3.mem_err, if3.read_data, led3); end
            end
            if (if0.mem_err) chk("err_needs_ready", 0, 32'(if0.mem_ready), 32'd1);
            if (if3.mem_err) chk("err_needs_ready", 1, 32'(if3.mem_ready), 32'd1);
            if (q0.size() > 0 && cyc - q0[0].sample_cyc > TMO) begin
                chk("response_timeout", 0, 32'd0, 32'd1); void'(q0.pop_front());
            end
            if (q1.size() > 0 && cyc - q1[0].sample_cyc > TMO) begin
                chk("response_timeout", 1, 32'd0, 32'd1); void'(q1.pop_front());
            end
            if (rst_req[0] != rst_done[0]) begin
                chk("rst_read_data", 0, 32'(if0.read_data), 32'd0);
                chk("rst_ready", 0, 32'(if0.mem_ready), 32'd0);
                chk("rst_err", 0, 32'(if0.mem_err), 32'd0);
                chk("rst_led", 0, 32'(led0), 32'd0);
                rst_done[0]++;
            end
            if (rst_req[1] != rst_done[1]) begin
                chk("rst_read_data", 1, 32'(if3.read_data), 32'd0);
                chk("rst_ready", 1, 32'(if3.mem_ready), 32'd0);
                chk("rst_err", 1, 32'(if3.mem_err), 32'd0);
                chk("rst_led", 1, 32'(led3), 32'd0);
                rst_done[1]++;
            end
            if (final_req && !final_done) begin
                chk("pending_responses", 0, q0.size(), 32'd0);
                chk("pending_responses", 1, q1.size(), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [1:0] c;
        logic [8:0] a;
        int         r;
        rst0 = 1'b1; rst3 = 1'b1; sw0 = 8'h00; sw3 = 8'h00;
        drive(0, 2'b00, 9'h000, 16'h0000);
        drive(1, 2'b00, 9'h000, 16'h0000);
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mdl_rd[d] = 16'h0000; mdl_led[d] = 8'h00; rst_req[d]++;
        end
        repeat (2) @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                issue(d, 2'b01, 9'(i), 16'($urandom), 8'($urandom));

        issue(0, 2'b01, 9'd5, 16'hBEEF, 8'h00);
        issue(0, 2'b10, 9'd5, 16'h0000, 8'h00);
        issue(0, 2'b10, 9'h1FF, 16'h0000, 8'h00);
        issue(0, 2'b11, 9'd5, 16'h5555, 8'h00);
        issue(0, 2'b10, 9'd5, 16'h0000, 8'h00);

        issue(1, 2'b10, 9'd0, 16'h0000, 8'h00);
        issue(1, 2'b01, 9'd7, 16'h0707, 8'h00);
        drive(1, 2'b01, 9'd7, 16'h1234);
        @(negedge clk);
        drive(1, 2'b00, 9'd7, 16'h1234);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        mdl_rd[1] = 16'h0000; mdl_led[1] = 8'h00; rst_req[1]++;
        issue(1, 2'b10, 9'd7, 16'h0000, 8'h00);

        issue(0, 2'b10, 9'h140, 16'h0000, 8'hA5);
        issue(0, 2'b01, 9'h100, 16'h3C7E, 8'h00);
        issue(0, 2'b01, 9'h140, 16'h1111, 8'h00);
        issue(0, 2'b10, 9'h100, 16'h0000, 8'h00);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 150; i++) begin
                r = int'($urandom_range(0, 9));
                c = (r < 4) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                r = int'($urandom_range(0, 9));
                a = (r < 6) ? 9'($urandom_range(0, 255)) : (r == 6) ? 9'h100 :
                    (r == 7) ? 9'h140 : (r == 8) ? 9'h1FF : 9'($urandom_range(256, 511));
                issue(d, c, a, 16'($urandom), 8'($urandom));
            end

        // Held READ for six edges: transactions sampled on edges 1, 3 and 5.
        a = 9'($urandom_range(0, 255));
        sw0 = 8'h00;
        for (int k = 0; k < 3; k++) q0.push_back(predict(0, 2'b10, a, 16'h0000, 8'h00, cyc + 1 + 2 * k));
        drive(0, 2'b10, a, 16'h0000);
        repeat (6) @(negedge clk);
        drive(0, 2'b00, 9'h000, 16'h0000);

        repeat (20) @(negedge clk);
        final_req = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) @(negedge clk);
        if (!final_done) begin
            errors++;
            $display("FAIL drain_check: got not_done expected done");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU control FSM's 2-bit mem_cmd bus.
- Accepts read/write commands, services on-chip RAM (and MMIO when enabled), and returns read data with a ready/error pulse.
- Sits between the datapath address/data mux and the RAM/board I/O; it is the target end of the interface the control FSM initiates.

Parameters:
- ADDR_W, 9, address width in words.
- DATA_W, 16, data word width.
- DEPTH, 256, RAM words; addresses 0..DEPTH-1 map to RAM.
- WAIT_CYCLES, 0, extra stall cycles inserted before each response (0..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_cmd  in  2  00 NONE, 01 WRITE, 10 READ, 11 illegal.
- mem_addr  in  ADDR_W  word address.
- write_data  in  DATA_W  store data.
- read_data  out  DATA_W  load data; valid while mem_ready=1 for a READ, held afterwards.
- mem_ready  out  1  one-cycle pulse: command completed.
- mem_err  out  1  one-cycle pulse with mem_ready: illegal cmd or unmapped address.
- sw_in  in  8  board switches (used only with MMIO_EN).
- led_out  out  8  board LEDs (driven only with MMIO_EN, else constant 0).

Behaviour:
- Reset (synchronous, active-high; fixed): state=IDLE, read_data=0, mem_ready=0, mem_err=0, led_out=0, wait counter=0. RAM contents are not cleared.
- States are IDLE, WAIT and RESP.
- IDLE:
  - If mem_cmd!=00, latch cmd/addr/data.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
  - mem_cmd=00 stays in IDLE with no side effects.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0 go to RESP.
  - Input changes during WAIT are ignored; the latched command is serviced.
- RESP (exactly one cycle):
  - mem_ready=1.
  - READ RAM: read_data=RAM[addr].
  - WRITE RAM: RAM[addr]<=data on this clock edge.
  - Next state is IDLE.
- Latency: with WAIT_CYCLES=0, a command sampled at edge N sees mem_ready and data at edge N+1. General latency is 1+WAIT_CYCLES cycles.
- Back-to-back commands: a new command is sampled in the IDLE cycle after RESP. A requester holding mem_cmd steady therefore gets one transaction every 2+WAIT_CYCLES cycles.
- Address decode: addr<DEPTH maps to RAM. Any other address is unmapped (see MMIO_EN): no write, read_data unchanged, mem_err=1 alongside mem_ready.
- Illegal cmd 11: handled like an unmapped access (ready+err, no side effects).
- Read-after-write to the same address returns the new value; there is no write-through hazard because accesses are serialized.
- Reset in WAIT or RESP: the transaction is aborted, the pending write is suppressed, and outputs return to reset values on that edge.
- Width: address compare is unsigned. Data is passed unmodified with no extension.

Optional Feature:
- Macro: MEM_RESPONDER_MMIO_EN.
- Defined:
  - Address 9'h140 READ returns {8'h00, sw_in}, sampled in RESP.
  - Address 9'h100 WRITE sets led_out<=write_data[7:0].
  - Writes to 9'h140 and reads from 9'h100 are errors.
  - DEPTH must be ≤ 9'h100 so there is no overlap.
- Undefined: 9'h100/9'h140 are ordinary unmapped addresses (error), sw_in is unused, and led_out is tied to 0.

Decomposition:
- Shared package mem_pkg:
  - mem_cmd_t enum: MEM_NONE=2'b00, MEM_WRITE=2'b01, MEM_READ=2'b10, MEM_ILLEGAL=2'b11.
  - Constants MMIO_LED_ADDR=9'h100 and MMIO_SW_ADDR=9'h140.
  - The control FSM imports the same enum.
- Sub-module ram_sp: single-port synchronous RAM with parameters DATA_W/DEPTH and ports clk, we, addr, din, dout, with one-cycle read latency. mem_responder issues the RAM read in IDLE/WAIT so dout is valid in RESP.

Test Plan:
- WAIT_CYCLES=0: WRITE addr 5 data 16'hBEEF, then READ addr 5 -> mem_ready one cycle after each command sample; read_data=16'hBEEF with err=0.
- WAIT_CYCLES=3: READ addr 0 -> mem_ready exactly 4 cycles after sampling. Change mem_addr during WAIT -> response still reflects addr 0.
- Unmapped/illegal: READ addr 9'h1FF -> ready=1, err=1, read_data unchanged. mem_cmd=11 -> ready+err, no RAM write (verify by re-reading).
- Reset mid-op: WRITE addr 7 data 16'h1234 with WAIT_CYCLES=2, assert reset during WAIT -> after reset, READ addr 7 returns its prior value; led_out=0, ready=0.
- MMIO_EN: sw_in=8'hA5, READ 9'h140 -> read_data=16'h00A5. WRITE 9'h100 data 16'h3C7E -> led_out=8'h7E. WRITE 9'h140 -> err=1.
- Back-to-back: hold mem_cmd=READ for 6 cycles at WAIT_CYCLES=0 -> exactly 3 ready pulses, with spacing of 2 cycles.
